// File: rtl/matriz_pkg.sv
// Shared definitions for the LED matrix scan controller: state encoding,
// default geometry/timing and the column-slice helper.
package matriz_pkg;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] APAGADO = 2'd1;
  localparam logic [1:0] ACESO   = 2'd2;

  localparam int NUM_COLUNAS_PADRAO   = 5;
  localparam int NUM_LINHAS_PADRAO    = 7;
  localparam int TEMPO_COLUNA_PADRAO  = 4;
  localparam int TEMPO_APAGADO_PADRAO = 1;

  // Widest frame/column the slice helper handles; callers zero-extend and truncate.
  localparam int MAX_QUADRO_W = 256;
  localparam int MAX_LINHAS_W = 32;

  function automatic logic [MAX_LINHAS_W-1:0] fatia_coluna(
    input logic [MAX_QUADRO_W-1:0] quadro,
    input int unsigned             coluna,
    input int unsigned             num_linhas
  );
    return MAX_LINHAS_W'(quadro >> (coluna * num_linhas)) &
           ~({MAX_LINHAS_W{1'b1}} << num_linhas);
  endfunction

endpackage

// File: rtl/controlador_matriz_contador_permanencia.sv
// Loadable dwell timer: restarts at 0 on carga, flags the last cycle of a
// dwell of length limite.
module contador_permanencia
  import matriz_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         frequencia_display,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] limite,
  output logic         terminou,
  output logic [W-1:0] contagem
);

  logic [W-1:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q + W'(1);
    if (carga) contagem_d = '0;
  end

  always_ff @(posedge frequencia_display) begin
    if (reset) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

  assign contagem = contagem_q;
  assign terminou = (contagem_q == limite - W'(1));

endmodule

// File: rtl/controlador_matriz.sv
// 5x7 LED matrix scan controller with tear-free shadow/active frame buffers.
// Optional brightness control is enabled with `define MATRIZ_BRILHO_EN.
module controlador_matriz
  import matriz_pkg::*;
#(
  parameter int NUM_COLUNAS   = NUM_COLUNAS_PADRAO,
  parameter int NUM_LINHAS    = NUM_LINHAS_PADRAO,
  parameter int TEMPO_COLUNA  = TEMPO_COLUNA_PADRAO,
  parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
  input  logic                            frequencia_display,
  input  logic                            reset,
  input  logic [NUM_COLUNAS*NUM_LINHAS-1:0] quadro_dados,
`ifdef MATRIZ_BRILHO_EN
  input  logic [1:0]                      brilho,
`endif
  input  logic                            quadro_valido,
  output logic                            quadro_pronto,
  output logic [NUM_COLUNAS-1:0]          colunas,
  output logic [NUM_LINHAS-1:0]           linhas,
  output logic [2:0]                      indice_coluna,
  output logic                            fim_quadro
);

  localparam int QW        = NUM_COLUNAS * NUM_LINHAS;
  localparam int TEMPO_MAX = (TEMPO_COLUNA > TEMPO_APAGADO) ? TEMPO_COLUNA : TEMPO_APAGADO;
  localparam int CW        = $clog2(TEMPO_MAX + 1);

  logic [1:0]    estado_q, estado_d;
  logic [2:0]    indice_q, indice_d;
  logic [QW-1:0] ativo_q, ativo_d;
  logic [QW-1:0] sombra_q, sombra_d;
  logic          sombra_cheia_q, sombra_cheia_d;

  logic          aceita, fim, carga, terminou, aceso, linhas_acesas;
  logic [CW-1:0] limite, contagem;
  logic [31:0]   limiar_brilho;
  logic [NUM_LINHAS-1:0] dados_coluna;

  assign limite = (estado_q == APAGADO) ? CW'(TEMPO_APAGADO) : CW'(TEMPO_COLUNA);
  // OCIOSO holds the timer at 0 so the first APAGADO starts a fresh dwell.
  assign carga  = (estado_q == OCIOSO) || terminou;

  contador_permanencia #(.W(CW)) u_permanencia (
    .frequencia_display (frequencia_display),
    .reset              (reset),
    .carga              (carga),
    .limite             (limite),
    .terminou           (terminou),
    .contagem           (contagem)
  );

  assign aceita = quadro_valido && !sombra_cheia_q;
  assign aceso  = (estado_q == ACESO);
  assign fim    = aceso && terminou && (indice_q == 3'(NUM_COLUNAS - 1));

  always_comb begin
    estado_d       = estado_q;
    indice_d       = indice_q;
    ativo_d        = ativo_q;
    sombra_d       = sombra_q;
    sombra_cheia_d = sombra_cheia_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          estado_d = APAGADO;
          ativo_d  = quadro_dados;
        end
      end
      APAGADO: if (terminou) estado_d = ACESO;
      ACESO: begin
        if (terminou) begin
          estado_d = APAGADO;
          indice_d = fim ? 3'd0 : indice_q + 3'd1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // Active buffer only changes at the frame boundary, so a frame never tears.
    if (estado_q != OCIOSO) begin
      if (fim && sombra_cheia_q) begin
        ativo_d        = sombra_q;
        sombra_cheia_d = 1'b0;
      end else if (fim && aceita) begin
        ativo_d = quadro_dados;
      end else if (aceita) begin
        sombra_d       = quadro_dados;
        sombra_cheia_d = 1'b1;
      end
    end
  end

  always_ff @(posedge frequencia_display) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      indice_q       <= '0;
      ativo_q        <= '0;
      sombra_q       <= '0;
      sombra_cheia_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      indice_q       <= indice_d;
      ativo_q        <= ativo_d;
      sombra_q       <= sombra_d;
      sombra_cheia_q <= sombra_cheia_d;
    end
  end

`ifdef MATRIZ_BRILHO_EN
  logic [1:0] brilho_q, brilho_d;

  assign brilho_d = ((estado_q == APAGADO) && terminou) ? brilho : brilho_q;

  always_ff @(posedge frequencia_display) begin
    if (reset) brilho_q <= '0;
    else       brilho_q <= brilho_d;
  end

  assign limiar_brilho = (32'(brilho_q) + 32'd1) * 32'(TEMPO_COLUNA / 4);
`else
  assign limiar_brilho = 32'(TEMPO_COLUNA);
`endif

  assign linhas_acesas = (32'(contagem) < limiar_brilho);
  assign dados_coluna  = NUM_LINHAS'(fatia_coluna(MAX_QUADRO_W'(ativo_q), 32'(indice_q),
                                                  32'(NUM_LINHAS)));

  assign colunas       = aceso ? ~(NUM_COLUNAS'(1) << indice_q) : '1;
  assign linhas        = (aceso && linhas_acesas) ? dados_coluna : '0;
  assign indice_coluna = indice_q;
  assign fim_quadro    = fim;
  assign quadro_pronto = !sombra_cheia_q;

endmodule

// File: tb/tb_controlador_matriz.sv
// Self-checking bench for controlador_matriz: position-based scan model plus
// hand-computed literal checks; brightness paths follow MATRIZ_BRILHO_EN.
module tb_controlador_matriz;

  localparam int NC  = 5;
  localparam int NL  = 7;
  localparam int TC  = 4;
  localparam int TA  = 1;
  localparam int CP  = TA + TC;
  localparam int PER = NC * CP;
  localparam int QW  = NC * NL;

  logic          clk;
  logic          reset;
  logic [QW-1:0] quadro_dados;
  logic          quadro_valido;
  logic          quadro_pronto;
  logic [NC-1:0] colunas;
  logic [NL-1:0] linhas;
  logic [2:0]    indice_coluna;
  logic          fim_quadro;
  logic [1:0]    brilho;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state: scan position within the frame period, buffers and shadow flag.
  bit            m_loaded, m_full, m_acc;
  int            m_pos;
  logic [QW-1:0] m_active, m_shadow;
  logic [1:0]    m_br;

  controlador_matriz #(
    .NUM_COLUNAS(NC), .NUM_LINHAS(NL), .TEMPO_COLUNA(TC), .TEMPO_APAGADO(TA)
  ) dut (
    .frequencia_display (clk),
    .reset              (reset),
    .quadro_dados       (quadro_dados),
`ifdef MATRIZ_BRILHO_EN
    .brilho             (brilho),
`endif
    .quadro_valido      (quadro_valido),
    .quadro_pronto      (quadro_pronto),
    .colunas            (colunas),
    .linhas             (linhas),
    .indice_coluna      (indice_coluna),
    .fim_quadro         (fim_quadro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nome, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_loaded = 0; m_full = 0; m_pos = 0; m_active = '0; m_shadow = '0; m_br = '0;
    end else begin
      m_acc = quadro_valido && !m_full;
      if (!m_loaded) begin
        if (m_acc) begin
          m_active = quadro_dados; m_loaded = 1; m_pos = 0;
        end
      end else begin
        if (m_pos == PER - 1 && m_full) begin
          m_active = m_shadow; m_full = 0;
        end else if (m_pos == PER - 1 && m_acc) begin
          m_active = quadro_dados;
        end else if (m_acc) begin
          m_shadow = quadro_dados; m_full = 1;
        end
        m_pos = (m_pos + 1) % PER;
      end
      if (m_loaded && (m_pos % CP) == TA) m_br = brilho;
    end
  end

  always @(negedge clk) begin
    int            col, w;
    logic [NC-1:0] ec;
    logic [NL-1:0] el;
    logic [2:0]    ei;
    logic          ef;
    if (chk_en) begin
      ec = '1; el = '0; ei = '0; ef = 1'b0;
      if (m_loaded) begin
        col = m_pos / CP;
        w   = m_pos % CP;
        ei  = 3'(col);
        ef  = (m_pos == PER - 1);
        if (w >= TA) begin
          ec = ~(NC'(1) << col);
          el = NL'(m_active >> (col * NL));
`ifdef MATRIZ_BRILHO_EN
          if ((w - TA) >= (int'(m_br) + 1) * TC / 4) el = '0;
`endif
        end
      end
      check("colunas", 64'(colunas), 64'(ec));
      check("linhas", 64'(linhas), 64'(el));
      check("indice_coluna", 64'(indice_coluna), 64'(ei));
      check("fim_quadro", 64'(fim_quadro), 64'(ef));
      check("quadro_pronto", 64'(quadro_pronto), 64'(!m_full));
    end
  end

  initial begin
    logic [QW-1:0] qa;
    bit found;
    reset = 1'b1; quadro_valido = 1'b0; quadro_dados = '0; brilho = 2'd3;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_colunas", 64'(colunas), 64'h1F);
    check("reset_pronto", 64'(quadro_pronto), 64'd1);
    reset = 1'b0;

    repeat (50) @(negedge clk);
    check("idle_colunas", 64'(colunas), 64'h1F);
    check("idle_linhas", 64'(linhas), 64'd0);
    check("idle_pronto", 64'(quadro_pronto), 64'd1);

    // Frame A: column 0 = 55h, column 4 = 2Ah.
    qa = QW'({$urandom(), $urandom()});
    qa[6:0]   = 7'h55;
    qa[34:28] = 7'h2A;
    quadro_dados = qa; quadro_valido = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (k == 1) begin
        quadro_valido = 1'b0; quadro_dados = QW'({$urandom(), $urandom()});
      end
      if (k == 2) begin
        check("A_k2_colunas", 64'(colunas), 64'h1E);
        check("A_k2_linhas", 64'(linhas), 64'h55);
      end
      if (k == 5) check("A_k5_linhas", 64'(linhas), 64'h55);
      if (k == 6) begin
        check("A_k6_colunas", 64'(colunas), 64'h1F);
        check("A_k6_indice", 64'(indice_coluna), 64'd1);
      end
      if (k == 22) begin
        check("A_k22_colunas", 64'(colunas), 64'h0F);
        check("A_k22_linhas", 64'(linhas), 64'h2A);
        check("A_k22_indice", 64'(indice_coluna), 64'd4);
      end
      if (k == 24) check("A_k24_fim", 64'(fim_quadro), 64'd0);
      if (k == 25) check("A_k25_fim", 64'(fim_quadro), 64'd1);
      if (k == 50) check("A_k50_fim", 64'(fim_quadro), 64'd1);
    end

    // Frame B offered mid-scan.
    repeat (7) @(negedge clk);
    quadro_dados = QW'({$urandom(), $urandom()}); quadro_valido = 1'b1;
    @(negedge clk);
    check("B_pronto_drop", 64'(quadro_pronto), 64'd0);
    quadro_valido = 1'b0;
    repeat (40) @(negedge clk);

    // Frame C: valido held high with data changing every cycle.
    quadro_valido = 1'b1;
    repeat (80) begin
      quadro_dados = QW'({$urandom(), $urandom()});
      @(negedge clk);
    end
    quadro_valido = 1'b0;

    // Reset during column 2 lit phase.
    found = 0;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      @(negedge clk);
      if (m_loaded && (m_pos / CP) == 2 && (m_pos % CP) >= TA) found = 1;
    end
    check("col2_reached", 64'(found), 64'd1);
    check("col2_colunas", 64'(colunas), 64'h1B);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_colunas", 64'(colunas), 64'h1F);
    check("rst_mid_linhas", 64'(linhas), 64'd0);
    check("rst_mid_indice", 64'(indice_coluna), 64'd0);
    check("rst_mid_pronto", 64'(quadro_pronto), 64'd1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_colunas", 64'(colunas), 64'h1F);

`ifdef MATRIZ_BRILHO_EN
    brilho = 2'd1;
    quadro_dados = '0; quadro_dados[6:0] = 7'h7F; quadro_valido = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      quadro_valido = 1'b0;
      if (k >= 2) check("br_colunas", 64'(colunas), 64'h1E);
      if (k == 2 || k == 3) check("br_linhas_on", 64'(linhas), 64'h7F);
      if (k == 4 || k == 5) check("br_linhas_off", 64'(linhas), 64'd0);
    end
`endif

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      quadro_valido = ($urandom_range(0, 3) == 0);
      quadro_dados  = QW'({$urandom(), $urandom()});
      reset         = ($urandom_range(0, 499) == 0);
      brilho        = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    reset = 1'b0; quadro_valido = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_matriz.md
Name: controlador_matriz

Overview:
Scan controller for the 5x7 LED matrix display: sequences column strobes and row data so a stored frame is shown by multiplexing.
Accepts new frames from the character/text logic over a valid/ready handshake into a shadow buffer. Swaps the shadow into the active buffer only at frame boundaries, so a frame never tears.
Inserts a blanking interval between columns to suppress ghosting; replaces the free-running column counter as the display's sequencer.

Parameters:
NUM_COLUNAS, 5, number of matrix columns scanned (2..8)
NUM_LINHAS, 7, number of rows per column
TEMPO_COLUNA, 4, cycles a column is lit (>=1)
TEMPO_APAGADO, 1, blanking cycles before each column (>=1)

Ports:
frequencia_display  in   1                        display scan clock, rising edge
reset               in   1                        synchronous, active-high
quadro_dados        in   NUM_COLUNAS*NUM_LINHAS   frame; column c row r = bit c*NUM_LINHAS+r
quadro_valido       in   1                        frame offered
quadro_pronto       out  1                        shadow buffer free; transfer when valido&&pronto
colunas             out  NUM_COLUNAS              active-low one-hot column strobe
linhas              out  NUM_LINHAS               active-high row data of lit column
indice_coluna       out  3                        current column index
fim_quadro          out  1                        1-cycle pulse, last ACESO cycle of last column

Behaviour:
- Reset (synchronous, active-high; takes effect at the edge where reset=1):
  - state OCIOSO; active and shadow buffers cleared; shadow marked empty.
  - colunas all 1; linhas 0; indice_coluna 0; fim_quadro 0; quadro_pronto 1.
  - Reset mid-scan discards both buffers; no partial column completes.
- States:
  - OCIOSO: no frame ever loaded; outputs blank. An accept here writes straight into the active buffer. Next cycle is APAGADO, column 0.
  - APAGADO: colunas all 1, linhas 0, for TEMPO_APAGADO cycles; then ACESO.
  - ACESO: colunas[indice]=0, others 1; linhas = active bits of that column; lasts TEMPO_COLUNA cycles.
    - End of ACESO with indice<NUM_COLUNAS-1: indice+1, go to APAGADO.
    - End of ACESO on last column: indice wraps to 0, go to APAGADO, fim_quadro pulses on that last ACESO cycle.
- Dwell counter: reloads on every state entry; counts from 0 to limit-1.
- Timing: column period is TEMPO_APAGADO+TEMPO_COLUNA; frame period is NUM_COLUNAS times that (25 cycles with defaults).
- Handshake:
  - quadro_pronto = shadow empty (registered).
  - Accept on valido&&pronto: data captured into shadow, shadow marked full, pronto drops the next cycle.
  - Data need not be held after acceptance. valido may stay high; a second frame is accepted only once the shadow is free again.
- Frame swap happens on the fim_quadro cycle:
  - If shadow is full: shadow copies into active, shadow becomes empty, pronto rises the next cycle.
  - If shadow is empty and an accept occurs in that same cycle: incoming data bypasses to active.
  - Otherwise the active frame repeats indefinitely.
- Once out of OCIOSO, the block never returns there except by reset.
- indice_coluna never exceeds NUM_COLUNAS-1.

Optional Feature:
MATRIZ_BRILHO_EN
- Defined:
  - Adds input brilho[1:0].
  - In ACESO, linhas carry column data only while dwell count < (brilho+1)*TEMPO_COLUNA/4; they are 0 for the rest of the dwell. colunas timing is unchanged.
  - brilho is sampled on entry to each ACESO.
  - TEMPO_COLUNA must be a multiple of 4.
- Undefined: no brilho port; linhas are driven for the full dwell.

Decomposition:
- Package matriz_pkg holds:
  - state encoding constants OCIOSO=2'd0, APAGADO=2'd1, ACESO=2'd2;
  - default parameter constants;
  - function for the column slice of the frame vector.
- Natural sub-module: contador_permanencia, a loadable dwell timer with inputs carga and limite and outputs terminou and contagem.

Test Plan:
- Reset then quadro_valido=0 for 50 cycles -> colunas=5'b11111, linhas=0, quadro_pronto=1 throughout.
- Accept frame with column 0 = 7'h55 and column 4 = 7'h2A:
  - next cycle APAGADO;
  - cycles 2-5 after accept: colunas=5'b11110, linhas=7'h55;
  - column 4 lit at cycles 22-25;
  - fim_quadro high only on cycle 25; pattern repeats with period 25.
- Offer frame B mid-scan of frame A:
  - pronto drops next cycle;
  - A is displayed to the end of its frame, B starts at column 0 after fim_quadro;
  - pronto rises the cycle after the swap.
- Hold valido=1 with a changing frame C while the shadow is full -> not accepted until pronto=1; the captured value is the one present on the accept edge.
- Assert reset during column 2 ACESO -> next cycle all outputs at reset values, pronto=1, buffers cleared.
- With MATRIZ_BRILHO_EN and brilho=2'd1, TEMPO_COLUNA=4 -> linhas valid for 2 cycles, then 0 for 2 cycles, colunas strobe for the full 4 cycles.
